// File: rtl/count_watch_pkg.sv
// Shared types for count_watch: tracker states, event flag positions,
// the packed FIFO event record and the per-step classifier.
package count_watch_pkg;

  typedef enum logic {
    TRK_INIT,
    TRK_TRACK
  } trk_state_e;

  localparam int unsigned FLAG_JUMP  = 0;
  localparam int unsigned FLAG_WRAP  = 1;
  localparam int unsigned FLAG_MATCH = 2;

  typedef struct packed {
    logic [2:0] flags;
    logic [7:0] data;
    logic [7:0] prev;
  } evt_t;

  localparam int unsigned EVT_W = $bits(evt_t);

  // Stalls (c == prev) raise nothing, which also suppresses match.
  function automatic logic [2:0] classify_step(input logic [7:0] c,
                                               input logic [7:0] prev,
                                               input logic [7:0] match_value,
                                               input logic       match_en);
    logic [2:0] fl;
    logic [7:0] prev_inc;
    fl       = '0;
    prev_inc = prev + 8'd1;
    if (c != prev) begin
      if (prev == 8'hFF && c == 8'h00) begin
        fl[FLAG_WRAP] = 1'b1;
      end else if (c != prev_inc) begin
        fl[FLAG_JUMP] = 1'b1;
      end
      if (match_en && c == match_value) begin
        fl[FLAG_MATCH] = 1'b1;
      end
    end
    return fl;
  endfunction

endpackage

// File: rtl/count_watch_fifo.sv
// Synchronous valid/ready FIFO; a push while full is accepted only when
// the head is popped on the same edge, otherwise it is reported as dropped.
module count_watch_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full;
  logic             pop;
  logic             push_acc;

  assign valid_o  = (cnt_q != '0);
  assign full     = (cnt_q == FULL_CNT);
  assign pop      = valid_o && ready_i;
  assign push_acc = push_i && (!full || pop);
  assign drop_o   = push_i && full && !pop;
  assign data_o   = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({push_acc, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/count_watch.sv
// Monitors an 8-bit counter bus, classifies each step, counts wraps and
// queues notable steps into an event FIFO for a slower consumer.
module count_watch
  import count_watch_pkg::*;
#(
  parameter int unsigned EVT_DEPTH = 4,
  parameter int unsigned WRAP_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        C,
  input  logic [7:0]        MATCH_VALUE,
  input  logic              MATCH_EN,
  output logic              MATCH,
  output logic              WRAP,
  output logic              JUMP,
  output logic [WRAP_W-1:0] WRAP_COUNT,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [2:0]        EVT_FLAGS,
  output logic [7:0]        EVT_DATA,
  output logic [7:0]        EVT_PREV,
  output logic              OVERFLOW
);

  trk_state_e        state_q, state_d;
  logic [7:0]        prev_q, prev_d;
  logic [2:0]        flags_d;
  logic              push_evt;
  evt_t              evt_in;
  evt_t              evt_head;
  logic [EVT_W-1:0]  fifo_dout;
  logic              fifo_drop;
  logic              match_q, wrap_q, jump_q;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              ovf_q, ovf_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= TRK_INIT;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // Every edge samples C into prev; INIT differs only in raising no flags.
  always_comb begin
    state_d = state_q;
    prev_d  = C;
    case (state_q)
      TRK_INIT:  state_d = TRK_TRACK;
      TRK_TRACK: state_d = TRK_TRACK;
      default:   state_d = TRK_INIT;
    endcase
  end

  always_comb begin
    flags_d = '0;
    if (state_q == TRK_TRACK) begin
      flags_d = classify_step(C, prev_q, MATCH_VALUE, MATCH_EN);
    end
    push_evt = |flags_d;
    evt_in   = '{flags: flags_d, data: C, prev: prev_q};
  end

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (flags_d[FLAG_WRAP] && wrap_cnt_q != '1) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
    ovf_d = ovf_q | fifo_drop;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      match_q    <= 1'b0;
      wrap_q     <= 1'b0;
      jump_q     <= 1'b0;
      wrap_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      match_q    <= flags_d[FLAG_MATCH];
      wrap_q     <= flags_d[FLAG_WRAP];
      jump_q     <= flags_d[FLAG_JUMP];
      wrap_cnt_q <= wrap_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  count_watch_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (EVT_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push_evt),
    .data_i  (evt_in),
    .valid_o (EVT_VALID),
    .ready_i (EVT_READY),
    .data_o  (fifo_dout),
    .drop_o  (fifo_drop)
  );

  assign evt_head   = fifo_dout;
  assign EVT_FLAGS  = evt_head.flags;
  assign EVT_DATA   = evt_head.data;
  assign EVT_PREV   = evt_head.prev;
  assign MATCH      = match_q;
  assign WRAP       = wrap_q;
  assign JUMP       = jump_q;
  assign WRAP_COUNT = wrap_cnt_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_count_watch.sv
// Self-checking bench for count_watch: hand-derived expected flags, a
// scoreboard queue of expected FIFO events, and a narrow-counter instance.
module tb_count_watch;

  localparam int unsigned DEPTH = 4;

  logic        CLK;
  logic        RESET;
  logic [7:0]  C;
  logic [7:0]  MATCH_VALUE;
  logic        MATCH_EN;
  logic        EVT_READY;
  logic        MATCH, WRAP, JUMP, EVT_VALID, OVERFLOW;
  logic [15:0] WRAP_COUNT;
  logic [2:0]  EVT_FLAGS;
  logic [7:0]  EVT_DATA, EVT_PREV;

  logic        MATCH2, WRAP2, JUMP2, EVT_VALID2, OVERFLOW2;
  logic [1:0]  WRAP_COUNT2;
  logic [2:0]  EVT_FLAGS2;
  logic [7:0]  EVT_DATA2, EVT_PREV2;

  count_watch #(.EVT_DEPTH(DEPTH), .WRAP_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .C(C), .MATCH_VALUE(MATCH_VALUE), .MATCH_EN(MATCH_EN),
    .MATCH(MATCH), .WRAP(WRAP), .JUMP(JUMP), .WRAP_COUNT(WRAP_COUNT),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_FLAGS(EVT_FLAGS),
    .EVT_DATA(EVT_DATA), .EVT_PREV(EVT_PREV), .OVERFLOW(OVERFLOW)
  );

  count_watch #(.EVT_DEPTH(DEPTH), .WRAP_W(2)) dut_sat (
    .CLK(CLK), .RESET(RESET), .C(C), .MATCH_VALUE(MATCH_VALUE), .MATCH_EN(MATCH_EN),
    .MATCH(MATCH2), .WRAP(WRAP2), .JUMP(JUMP2), .WRAP_COUNT(WRAP_COUNT2),
    .EVT_VALID(EVT_VALID2), .EVT_READY(EVT_READY), .EVT_FLAGS(EVT_FLAGS2),
    .EVT_DATA(EVT_DATA2), .EVT_PREV(EVT_PREV2), .OVERFLOW(OVERFLOW2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] fl;
    logic [7:0] d;
    logic [7:0] p;
  } exp_evt_t;

  typedef struct {
    logic [7:0] c;
    logic [7:0] mv;
    logic       men;
    logic       rdy;
    logic [2:0] fl;
  } vec_t;

  exp_evt_t    sb[$];
  vec_t        vecs[11];
  int          n_chk;
  int          n_pass;
  logic [7:0]  prev_m;
  logic        ovf_m;
  logic [15:0] wc_m;
  logic [1:0]  wc2_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One sample: exp_fl is the hand-derived flag set this C value must raise.
  task automatic step(input logic [7:0] c, input logic [7:0] mv, input logic men,
                      input logic rdy, input logic [2:0] exp_fl, input string nm);
    exp_evt_t e;
    @(negedge CLK);
    RESET       = 1'b0;
    C           = c;
    MATCH_VALUE = mv;
    MATCH_EN    = men;
    EVT_READY   = rdy;
    #1;
    check({nm, ".evt_valid"}, 32'(EVT_VALID), 32'(sb.size() != 0));
    if (EVT_VALID && sb.size() != 0) begin
      check({nm, ".evt_flags"}, 32'(EVT_FLAGS), 32'(sb[0].fl));
      check({nm, ".evt_data"},  32'(EVT_DATA),  32'(sb[0].d));
      check({nm, ".evt_prev"},  32'(EVT_PREV),  32'(sb[0].p));
    end
    if (rdy && sb.size() != 0) void'(sb.pop_front());
    if (exp_fl != 3'b000) begin
      if (sb.size() < DEPTH) begin
        e = '{fl: exp_fl, d: c, p: prev_m};
        sb.push_back(e);
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (exp_fl[1]) begin
      if (wc_m != 16'hFFFF) wc_m = wc_m + 16'd1;
      if (wc2_m != 2'b11) wc2_m = wc2_m + 2'd1;
    end
    prev_m = c;
    @(posedge CLK);
    #1;
    check({nm, ".match"},      32'(MATCH),       32'(exp_fl[2]));
    check({nm, ".wrap"},       32'(WRAP),        32'(exp_fl[1]));
    check({nm, ".jump"},       32'(JUMP),        32'(exp_fl[0]));
    check({nm, ".overflow"},   32'(OVERFLOW),    32'(ovf_m));
    check({nm, ".wrap_count"}, 32'(WRAP_COUNT),  32'(wc_m));
    check({nm, ".wrap_sat"},   32'(WRAP_COUNT2), 32'(wc2_m));
  endtask

  task automatic do_reset(input string nm);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    sb.delete();
    ovf_m = 1'b0;
    wc_m  = '0;
    wc2_m = '0;
    check({nm, ".match"},      32'(MATCH),       32'd0);
    check({nm, ".wrap"},       32'(WRAP),        32'd0);
    check({nm, ".jump"},       32'(JUMP),        32'd0);
    check({nm, ".evt_valid"},  32'(EVT_VALID),   32'd0);
    check({nm, ".overflow"},   32'(OVERFLOW),    32'd0);
    check({nm, ".wrap_count"}, 32'(WRAP_COUNT),  32'd0);
    check({nm, ".evt_flags"},  32'(EVT_FLAGS),   32'd0);
    check({nm, ".evt_data"},   32'(EVT_DATA),    32'd0);
    check({nm, ".evt_prev"},   32'(EVT_PREV),    32'd0);
    check({nm, ".wrap_sat"},   32'(WRAP_COUNT2), 32'd0);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    prev_m      = '0;
    ovf_m       = 1'b0;
    wc_m        = '0;
    wc2_m       = '0;
    RESET       = 1'b1;
    C           = '0;
    MATCH_VALUE = '0;
    MATCH_EN    = 1'b0;
    EVT_READY   = 1'b1;

    vecs[0]  = '{c: 8'd44,  mv: 8'd44,  men: 1'b1, rdy: 1'b1, fl: 3'b100};
    vecs[1]  = '{c: 8'd44,  mv: 8'd44,  men: 1'b1, rdy: 1'b1, fl: 3'b000};
    vecs[2]  = '{c: 8'd45,  mv: 8'd45,  men: 1'b0, rdy: 1'b1, fl: 3'b000};
    vecs[3]  = '{c: 8'd255, mv: 8'd0,   men: 1'b1, rdy: 1'b1, fl: 3'b001};
    vecs[4]  = '{c: 8'd0,   mv: 8'd0,   men: 1'b1, rdy: 1'b1, fl: 3'b110};
    vecs[5]  = '{c: 8'd1,   mv: 8'd0,   men: 1'b1, rdy: 1'b1, fl: 3'b000};
    vecs[6]  = '{c: 8'd255, mv: 8'd0,   men: 1'b0, rdy: 1'b1, fl: 3'b001};
    vecs[7]  = '{c: 8'd7,   mv: 8'd0,   men: 1'b0, rdy: 1'b1, fl: 3'b001};
    vecs[8]  = '{c: 8'd8,   mv: 8'd0,   men: 1'b0, rdy: 1'b1, fl: 3'b000};
    vecs[9]  = '{c: 8'd6,   mv: 8'd0,   men: 1'b0, rdy: 1'b1, fl: 3'b001};
    vecs[10] = '{c: 8'd100, mv: 8'd100, men: 1'b1, rdy: 1'b1, fl: 3'b101};

    do_reset("reset0");

    // Free-running count from 0 through the first wrap.
    step(8'd0, 8'd0, 1'b0, 1'b1, 3'b000, "init");
    for (int i = 1; i <= 255; i++) step(8'(i), 8'd0, 1'b0, 1'b1, 3'b000, "run");
    step(8'd0, 8'd0, 1'b0, 1'b1, 3'b010, "wrap");
    for (int i = 1; i <= 27; i++) step(8'(i), 8'd0, 1'b0, 1'b1, 3'b000, "run2");

    // LOAD 42 held for two cycles with a match on 42.
    step(8'd42, 8'd42, 1'b1, 1'b1, 3'b101, "load");
    step(8'd42, 8'd42, 1'b1, 1'b1, 3'b000, "load_stall");
    step(8'd43, 8'd42, 1'b1, 1'b1, 3'b000, "after_load");

    for (int i = 0; i < 11; i++)
      step(vecs[i].c, vecs[i].mv, vecs[i].men, vecs[i].rdy, vecs[i].fl, $sformatf("vec%0d", i));

    // Five jumps into a stalled consumer, then drain.
    for (int i = 1; i <= 5; i++) step(8'(i * 10), 8'd0, 1'b0, 1'b0, 3'b001, "ovf_fill");
    for (int i = 0; i < 5; i++) step(8'd50, 8'd0, 1'b0, 1'b1, 3'b000, "ovf_drain");

    // Full FIFO with a jump arriving on the same edge as a pop.
    do_reset("reset1");
    step(8'd0, 8'd0, 1'b0, 1'b0, 3'b000, "init1");
    for (int i = 6; i <= 9; i++) step(8'(i * 10), 8'd0, 1'b0, 1'b0, 3'b001, "full_fill");
    step(8'd99, 8'd0, 1'b0, 1'b1, 3'b001, "full_pushpop");
    for (int i = 0; i < 5; i++) step(8'd99, 8'd0, 1'b0, 1'b1, 3'b000, "full_drain");

    // Reset with three queued events, then a discontinuous first sample.
    step(8'd255, 8'd0, 1'b0, 1'b0, 3'b001, "q_jump");
    step(8'd0,   8'd0, 1'b0, 1'b0, 3'b010, "q_wrap");
    step(8'd77,  8'd0, 1'b0, 1'b0, 3'b001, "q_jump2");
    do_reset("reset_mid");
    step(8'd123, 8'd0, 1'b0, 1'b1, 3'b000, "post_init");
    step(8'd124, 8'd0, 1'b0, 1'b1, 3'b000, "post_inc");

    // Four wraps: the 2-bit counter saturates at 3 and holds.
    for (int i = 0; i < 4; i++) begin
      step(8'd255, 8'd0, 1'b0, 1'b1, 3'b001, "sat_jump");
      step(8'd0,   8'd0, 1'b0, 1'b1, 3'b010, "sat_wrap");
    end
    step(8'd1, 8'd0, 1'b0, 1'b1, 3'b000, "sat_tail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
